// File: rtl/hex_rec_pkg.sv
// Shared constants for the Intel-HEX record decoder: parser states, record
// types, error codes and the ASCII characters the framer reacts to.
package hex_rec_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN   = 3'd1;
   localparam logic [2:0] ST_ADDR  = 3'd2;
   localparam logic [2:0] ST_TYPE  = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_CSUM  = 3'd5;
   localparam logic [2:0] ST_CHECK = 3'd6;

   localparam logic [7:0] REC_DATA = 8'h00;
   localparam logic [7:0] REC_EOF  = 8'h01;
   localparam logic [7:0] REC_ESA  = 8'h02;
   localparam logic [7:0] REC_ELA  = 8'h04;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_CHAR = 3'd1;
   localparam logic [2:0] ERR_HEX  = 3'd2;
   localparam logic [2:0] ERR_CSUM = 3'd3;
   localparam logic [2:0] ERR_TYPE = 3'd4;
   localparam logic [2:0] ERR_LEN  = 3'd5;

   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_SP    = 8'h20;

endpackage

// File: rtl/hex_nibble_dec.sv
// ASCII hex digit (0-9, A-F, a-f) to 4-bit value with a valid flag.
module hex_nibble_dec (
   input  logic [7:0] ch,
   output logic [3:0] nib,
   output logic       vld
);

   always_comb begin
      nib = 4'd0;
      vld = 1'b0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         nib = ch[3:0];
         vld = 1'b1;
      end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 lands on 10
         nib = ch[3:0] + 4'd9;
         vld = 1'b1;
      end
   end

endmodule

// File: rtl/hex_rec_decoder.sv
// Intel-HEX record decoder: ASCII character stream in, packed little-endian
// memory write cycles out, with checksum, typed sticky errors and EOF flag.
module hex_rec_decoder
   import hex_rec_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_BYTES = 1,
   parameter int EXT_EN     = 1
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic                    EN,
   input  logic [7:0]              DI,
   output logic [ADDR_W-1:0]       AB,
   output logic [8*DATA_BYTES-1:0] DB,
   output logic [DATA_BYTES-1:0]   BE,
   output logic                    WE,
   output logic                    ERR,
   output logic [2:0]              ERR_CODE,
   output logic                    DONE
);

   localparam int LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   logic [2:0]              state;
   logic                    ph;
   logic [3:0]              hi;
   logic [7:0]              len, rtype, bcnt, sum;
   logic [15:0]             offset, ext;
   logic [31:0]             base;
   logic [8*DATA_BYTES-1:0] wbuf, nbuf;
   logic [DATA_BYTES-1:0]   wbe, nbe;

   logic [3:0]        nib;
   logic              nib_vld;
   logic [7:0]        byte_v;
   logic [15:0]       off_i;
   logic [31:0]       addr_full;
   logic [ADDR_W-1:0] addr;
   logic [LW-1:0]     lane;
   logic              last_byte, flush;
   logic              idle_like, ws, eof_now, chk_base, take, err_set;
   logic [2:0]        chk_code, chr_code, err_val;

   hex_nibble_dec u_nib (
      .ch  (DI),
      .nib (nib),
      .vld (nib_vld)
   );

   always_comb begin
      byte_v    = {hi, nib};
      off_i     = offset + {8'd0, bcnt};
      addr_full = base + {16'd0, off_i};
      addr      = addr_full[ADDR_W-1:0];
      lane      = (DATA_BYTES == 1) ? '0 : LW'(addr);
      last_byte = (bcnt == len - 8'd1);
      flush     = (int'(lane) == DATA_BYTES - 1) || last_byte;
      nbuf      = wbuf;
      nbe       = wbe;
      for (int k = 0; k < DATA_BYTES; k++) begin
         if (int'(lane) == k) begin
            nbuf[8*k +: 8] = byte_v;
            nbe[k]         = 1'b1;
         end
      end
   end

   // Record verdict, only meaningful while sitting in CHECK
   always_comb begin
      chk_code = ERR_NONE;
      eof_now  = 1'b0;
      chk_base = 1'b0;
      if (sum != 8'd0) begin
         chk_code = ERR_CSUM;
      end else begin
         case (rtype)
            REC_DATA: ;
            REC_EOF: begin
               if (len != 8'd0) chk_code = ERR_LEN;
               else             eof_now  = (state == ST_CHECK);
            end
            REC_ESA, REC_ELA: begin
               if (EXT_EN == 0)        chk_code = ERR_TYPE;
               else if (len != 8'd2)   chk_code = ERR_LEN;
               else                    chk_base = 1'b1;
            end
            default: chk_code = ERR_TYPE;
         endcase
      end
      if (state != ST_CHECK) chk_code = ERR_NONE;
   end

   // CHECK also accepts a character, so a ':' arriving back-to-back is not lost
   always_comb begin
      idle_like = (state == ST_IDLE) || (state == ST_CHECK);
      ws        = (DI == ASC_CR) || (DI == ASC_LF) || (DI == ASC_SP);
      take      = EN && !DONE && !eof_now;
      chr_code  = ERR_NONE;
      if (take) begin
         if (idle_like) begin
            if (DI != ASC_COLON && !ws) chr_code = ERR_CHAR;
         end else if (!nib_vld) begin
            chr_code = ERR_HEX;
         end
      end
      err_set = (chk_code != ERR_NONE) || (chr_code != ERR_NONE);
      err_val = (chk_code != ERR_NONE) ? chk_code : chr_code;
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= ST_IDLE;
         ph       <= 1'b0;
         sum      <= 8'd0;
         base     <= 32'd0;
         wbuf     <= '0;
         wbe      <= '0;
         AB       <= '0;
         DB       <= '0;
         BE       <= '0;
         WE       <= 1'b1;
         ERR      <= 1'b0;
         ERR_CODE <= ERR_NONE;
         DONE     <= 1'b0;
      end else begin
         WE <= 1'b1;
         if (err_set) begin
            ERR <= 1'b1;
            if (!ERR) ERR_CODE <= err_val;
         end
         if (state == ST_CHECK) begin
            state <= ST_IDLE;
            if (eof_now) DONE <= 1'b1;
            if (chk_base) base <= (rtype == REC_ESA) ? {12'd0, ext, 4'd0} : {ext, 16'd0};
         end
         if (take) begin
            if (idle_like) begin
               if (DI == ASC_COLON) begin
                  state <= ST_LEN;
                  sum   <= 8'd0;
                  ph    <= 1'b0;
               end
            end else if (!nib_vld) begin
               state <= ST_IDLE;
               wbuf  <= '0;
               wbe   <= '0;
            end else if (!ph) begin
               hi <= nib;
               ph <= 1'b1;
            end else begin
               ph  <= 1'b0;
               sum <= sum + byte_v;
               case (state)
                  ST_LEN: begin
                     len   <= byte_v;
                     bcnt  <= 8'd0;
                     state <= ST_ADDR;
                  end
                  ST_ADDR: begin
                     if (bcnt == 8'd0) begin
                        offset[15:8] <= byte_v;
                        bcnt         <= 8'd1;
                     end else begin
                        offset[7:0] <= byte_v;
                        state       <= ST_TYPE;
                     end
                  end
                  ST_TYPE: begin
                     rtype <= byte_v;
                     bcnt  <= 8'd0;
                     state <= (len == 8'd0) ? ST_CSUM : ST_DATA;
                  end
                  ST_DATA: begin
                     if (rtype == REC_DATA) begin
                        if (flush) begin
                           WE   <= 1'b0;
                           AB   <= addr & ~ADDR_W'(DATA_BYTES - 1);
                           DB   <= nbuf;
                           BE   <= nbe;
                           wbuf <= '0;
                           wbe  <= '0;
                        end else begin
                           wbuf <= nbuf;
                           wbe  <= nbe;
                        end
                     end
                     if (bcnt == 8'd0)      ext[15:8] <= byte_v;
                     else if (bcnt == 8'd1) ext[7:0]  <= byte_v;
                     bcnt <= bcnt + 8'd1;
                     if (last_byte) state <= ST_CSUM;
                  end
                  ST_CSUM: state <= ST_CHECK;
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_rec_decoder.sv
// Bench for hex_rec_decoder: one byte-wide and one word-wide instance share a
// character stream; a record-level reference model predicts writes and flags.
module tb_hex_rec_decoder;

   typedef struct packed {
      logic [31:0] ab;
      logic [31:0] db;
      logic [3:0]  be;
   } wr_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        en  = 1'b0;
   logic [7:0]  di  = 8'h00;

   logic [31:0] ab1, ab4;
   logic [7:0]  db1;
   logic [31:0] db4;
   logic [0:0]  be1;
   logic [3:0]  be4;
   logic        we1, we4, err1, err4, done1, done4;
   logic [2:0]  code1, code4;

   int n_chk  = 0;
   int n_fail = 0;
   int gap_max = 0;

   wr_t expq0[$], expq1[$], obsq0[$], obsq1[$];

   // reference model state
   bit          m_err, m_done, m_inrec, m_ph;
   int          m_code, m_hi;
   int          m_bytes[$];
   logic [31:0] m_base;
   logic [31:0] pw_data[2];
   logic [3:0]  pw_be[2];

   hex_rec_decoder #(.ADDR_W(32), .DATA_BYTES(1), .EXT_EN(1)) u_dut1 (
      .CLK(clk), .CLR(clr), .EN(en), .DI(di), .AB(ab1), .DB(db1), .BE(be1),
      .WE(we1), .ERR(err1), .ERR_CODE(code1), .DONE(done1)
   );

   hex_rec_decoder #(.ADDR_W(32), .DATA_BYTES(4), .EXT_EN(1)) u_dut4 (
      .CLK(clk), .CLR(clr), .EN(en), .DI(di), .AB(ab4), .DB(db4), .BE(be4),
      .WE(we4), .ERR(err4), .ERR_CODE(code4), .DONE(done4)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!we1) obsq0.push_back('{ab: ab1, db: {24'd0, db1}, be: {3'd0, be1}});
      if (!we4) obsq1.push_back('{ab: ab4, db: db4, be: be4});
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
      return -1;
   endfunction

   task automatic model_reset();
      m_err = 0; m_done = 0; m_inrec = 0; m_ph = 0; m_code = 0; m_hi = 0;
      m_base = 32'd0;
      m_bytes.delete();
      for (int d = 0; d < 2; d++) begin
         pw_data[d] = 32'd0;
         pw_be[d]   = 4'd0;
      end
   endtask

   task automatic model_err(input int code);
      if (!m_err) m_code = code;
      m_err = 1;
   endtask

   task automatic model_byte();
      int n, len, off, i, sum, typ, nb, lane;
      logic [31:0] addr;
      n   = m_bytes.size();
      len = m_bytes[0];
      if (n >= 5 && m_bytes[3] == 0 && (n - 5) < len) begin
         i    = n - 5;
         off  = m_bytes[1] * 256 + m_bytes[2];
         addr = m_base + 32'((off + i) % 65536);
         for (int d = 0; d < 2; d++) begin
            nb   = (d == 0) ? 1 : 4;
            lane = int'(addr % nb);
            pw_data[d] = pw_data[d] | (32'(m_bytes[n-1]) << (8 * lane));
            pw_be[d]   = pw_be[d] | 4'(1 << lane);
            if (lane == nb - 1 || i == len - 1) begin
               if (d == 0) expq0.push_back('{ab: addr - 32'(lane), db: pw_data[d], be: pw_be[d]});
               else        expq1.push_back('{ab: addr - 32'(lane), db: pw_data[d], be: pw_be[d]});
               pw_data[d] = 32'd0;
               pw_be[d]   = 4'd0;
            end
         end
      end
      if (n == len + 5) begin
         m_inrec = 0;
         sum = 0;
         foreach (m_bytes[k]) sum += m_bytes[k];
         typ = m_bytes[3];
         if (sum % 256 != 0)               model_err(3);
         else if (typ == 0)                ;
         else if (typ == 1) begin
            if (len != 0) model_err(5);
            else          m_done = 1;
         end else if (typ == 2 || typ == 4) begin
            if (len != 2) model_err(5);
            else if (typ == 2) m_base = 32'(m_bytes[4] * 256 + m_bytes[5]) << 4;
            else               m_base = 32'(m_bytes[4] * 256 + m_bytes[5]) << 16;
         end else                          model_err(4);
      end
   endtask

   task automatic model_char(input logic [7:0] c);
      int v;
      if (m_done) return;
      if (!m_inrec) begin
         if (c == 8'h3A) begin
            m_inrec = 1;
            m_ph    = 0;
            m_bytes.delete();
         end else if (!(c == 8'h0D || c == 8'h0A || c == 8'h20)) begin
            model_err(1);
         end
         return;
      end
      v = hexval(c);
      if (v < 0) begin
         model_err(2);
         m_inrec = 0;
         for (int d = 0; d < 2; d++) begin
            pw_data[d] = 32'd0;
            pw_be[d]   = 4'd0;
         end
      end else if (!m_ph) begin
         m_hi = v;
         m_ph = 1;
      end else begin
         m_ph = 0;
         m_bytes.push_back(m_hi * 16 + v);
         model_byte();
      end
   endtask

   task automatic send_char(input logic [7:0] c);
      int gap;
      model_char(c);
      en = 1'b1;
      di = c;
      @(posedge clk); #1;
      en = 1'b0;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic settle();
      en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      en  = 1'b0;
      @(posedge clk); #1;
      clr = 1'b0;
      model_reset();
      obsq0.delete(); obsq1.delete(); expq0.delete(); expq1.delete();
   endtask

   task automatic check_reset();
      chk("rst_we1", we1, 1);      chk("rst_we4", we4, 1);
      chk("rst_ab1", ab1, 0);      chk("rst_ab4", ab4, 0);
      chk("rst_db1", db1, 0);      chk("rst_db4", db4, 0);
      chk("rst_be1", be1, 0);      chk("rst_be4", be4, 0);
      chk("rst_err1", err1, 0);    chk("rst_err4", err4, 0);
      chk("rst_code1", code1, 0);  chk("rst_code4", code4, 0);
      chk("rst_done1", done1, 0);  chk("rst_done4", done4, 0);
   endtask

   task automatic compare_all(input string tag);
      chk({tag, "_nwr1"}, obsq0.size(), expq0.size());
      for (int i = 0; i < obsq0.size() && i < expq0.size(); i++) begin
         chk({tag, "_ab1"}, obsq0[i].ab, expq0[i].ab);
         chk({tag, "_db1"}, obsq0[i].db, expq0[i].db);
         chk({tag, "_be1"}, obsq0[i].be, expq0[i].be);
      end
      chk({tag, "_nwr4"}, obsq1.size(), expq1.size());
      for (int i = 0; i < obsq1.size() && i < expq1.size(); i++) begin
         chk({tag, "_ab4"}, obsq1[i].ab, expq1[i].ab);
         chk({tag, "_db4"}, obsq1[i].db, expq1[i].db);
         chk({tag, "_be4"}, obsq1[i].be, expq1[i].be);
      end
      chk({tag, "_err1"}, err1, m_err);     chk({tag, "_err4"}, err4, m_err);
      chk({tag, "_code1"}, code1, m_code);  chk({tag, "_code4"}, code4, m_code);
      chk({tag, "_done1"}, done1, m_done);  chk({tag, "_done4"}, done4, m_done);
      obsq0.delete(); obsq1.delete(); expq0.delete(); expq1.delete();
   endtask

   task automatic make_rec(output string s);
      int r, len, typ, sum;
      logic [15:0] off;
      int b[$];
      bit bad_cs, bad_hex, up;
      r = int'($urandom_range(0, 99));
      len = int'($urandom_range(0, 8));
      typ = 0;
      bad_cs = 0;
      bad_hex = 0;
      off = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      if (r < 60)      ;
      else if (r < 68) begin typ = 4; len = 2; end
      else if (r < 74) begin typ = 2; len = 2; end
      else if (r < 80) bad_cs = 1;
      else if (r < 85) begin typ = 3 + 2 * int'($urandom_range(0, 2)); len = int'($urandom_range(0, 3)); end
      else if (r < 90) begin typ = 2; len = ($urandom_range(0, 1) == 0) ? 1 : 3; end
      else if (r < 95) bad_hex = 1;
      b.push_back(len);
      b.push_back(int'(off[15:8]));
      b.push_back(int'(off[7:0]));
      b.push_back(typ);
      for (int i = 0; i < len; i++) b.push_back(int'($urandom_range(0, 255)));
      sum = 0;
      foreach (b[i]) sum += b[i];
      b.push_back((256 - (sum % 256)) % 256 + (bad_cs ? 1 : 0));
      if (b[b.size()-1] > 255) b[b.size()-1] = 0;
      up = ($urandom_range(0, 1) == 1);
      s = ":";
      foreach (b[i]) begin
         if (up) s = {s, $sformatf("%02X", b[i])};
         else    s = {s, $sformatf("%02x", b[i])};
      end
      if (bad_hex) begin
         int p;
         p = int'($urandom_range(1, s.len() - 1));
         s = {s.substr(0, p - 1), "g", s.substr(p, s.len() - 1)};
      end
      if (r >= 95)                     s = {"x", s};
      else if ($urandom_range(0, 3) == 0) s = {"\r\n", s};
      else if ($urandom_range(0, 5) == 0) s = {" ", s};
   endtask

   initial begin
      string s;
      model_reset();
      @(posedge clk); #1;
      do_reset();
      check_reset();

      // plain data record, EN every cycle
      send_str(":0300300002337A1E");
      settle();
      chk("t1_n", obsq0.size(), 3);
      chk("t1_ab0", obsq0[0].ab, 32'h30);  chk("t1_db0", obsq0[0].db, 32'h02);
      chk("t1_ab1", obsq0[1].ab, 32'h31);  chk("t1_db1", obsq0[1].db, 32'h33);
      chk("t1_ab2", obsq0[2].ab, 32'h32);  chk("t1_db2", obsq0[2].db, 32'h7A);
      compare_all("t1");

      send_str(":020000040800F2");
      send_str(":0100000055AA");
      settle();
      chk("t2_ab", obsq0[0].ab, 32'h08000000);
      chk("t2_db", obsq0[0].db, 32'h55);
      compare_all("t2");

      do_reset();
      send_str(":0300300002337A1F");
      settle();
      chk("t3_code", code1, 3);
      compare_all("t3");

      do_reset();
      send_str(":00000001FF");
      send_str(":0100000055AA");
      settle();
      chk("t4_done", done1, 1);
      compare_all("t4");

      do_reset();
      send_str(":0300310002337A1D");
      settle();
      chk("t5_n4", obsq1.size(), 1);
      chk("t5_ab4", obsq1[0].ab, 32'h30);
      chk("t5_be4", obsq1[0].be, 4'b1110);
      chk("t5_db4", obsq1[0].db, 32'h7A330200);
      compare_all("t5");

      do_reset();
      send_str(":0G");
      send_str(":0300300002337A1E");
      settle();
      chk("t6_code", code1, 2);
      compare_all("t6");

      do_reset();
      send_str(":0300");
      do_reset();
      check_reset();
      send_str(":0300300002337A1E");
      settle();
      compare_all("t6b");

      do_reset();
      send_str(":01000001AA54");
      settle();
      chk("len_code", code4, 5);
      compare_all("len");

      do_reset();
      gap_max = 2;
      for (int n = 0; n < 80; n++) begin
         if (n == 40) do_reset();
         make_rec(s);
         send_str(s);
         settle();
         compare_all($sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
